// File: rtl/quant_amax_scaler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : quant_pkg
//  Purpose  : Shared fp32 constants, types and scale-derivation helpers for the
//             amax calibration stage ahead of the int8 quantizer.
//  Revision : 1.0  initial release
// ============================================================================
package quant_pkg;

  localparam logic [31:0] FP32_ONE      = 32'h3F80_0000;
  localparam logic [31:0] FP32_MIN_NORM = 32'h0080_0000;
  localparam logic [7:0]  FP32_EXP_INF  = 8'hFF;
  localparam int          SCALE_SHIFT   = 7;

  typedef logic [31:0] fp32_t;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SCALE   = 2'd1,
    REPLAY  = 2'd2
  } amax_state_t;

  // Inf and NaN share the all-ones exponent.
  function automatic logic is_nonfinite(input fp32_t x);
    return (x[30:23] == FP32_EXP_INF);
  endfunction

  // Sign-stripped word; unsigned ordering of this matches |x| for finite values.
  function automatic fp32_t magnitude(input fp32_t x);
    return x & 32'h7FFF_FFFF;
  endfunction

  // amax/128 by exponent decrement. Tiny amax clamps to the smallest normal so
  // the quantizer never sees a denormal scale; zero amax maps to 1.0.
  function automatic fp32_t amax_to_scale(input fp32_t amax);
    fp32_t s;
    if (amax == '0) begin
      s = FP32_ONE;
    end else if (amax[30:23] <= 8'(SCALE_SHIFT + 1)) begin
      s = FP32_MIN_NORM;
    end else begin
      s = {amax[31], amax[30:23] - 8'(SCALE_SHIFT), amax[22:0]};
    end
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/quant_amax_scaler_if.sv
`default_nettype none
// ============================================================================
//  Module   : quant_amax_scaler_if
//  Purpose  : Input stream, replay stream and error flags of the amax scaler.
//             master = producer/consumer side, slave = the scaler itself.
//  Revision : 1.0  initial release
// ============================================================================
interface quant_amax_scaler_if;
  import quant_pkg::*;

  logic  in_valid;
  logic  in_ready;
  fp32_t in_data;
  logic  in_last;

  logic  out_valid;
  logic  out_ready;
  fp32_t out_data;
  fp32_t out_scale;
  logic  out_last;

  logic  err_nonfin;
  logic  err_trunc;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_scale, out_last, err_nonfin, err_trunc
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_scale, out_last, err_nonfin, err_trunc
  );

endinterface
`default_nettype wire

// File: rtl/quant_amax_scaler_replay_buf.sv
`default_nettype none
// ============================================================================
//  Module   : quant_replay_buf
//  Purpose  : DEPTH x 32 simple dual-port buffer, one write and one registered
//             read port. The read register holds when no read is issued, so it
//             doubles as the stalled output word.
//  Revision : 1.0  initial release
// ============================================================================
module quant_replay_buf
  import quant_pkg::*;
#(
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  input  wire logic          we,
  input  wire logic [AW-1:0] waddr,
  input  wire fp32_t         wdata,
  input  wire logic          re,
  input  wire logic [AW-1:0] raddr,
  output      fp32_t         rdata
);

  fp32_t mem [DEPTH];
  fp32_t rdata_q;
  fp32_t rdata_d;

  // Storage array: contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port: fetch on request, otherwise keep the last word.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[raddr];
    end
  end

  // Read data register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/quant_amax_scaler.sv
`default_nettype none
// ============================================================================
//  Module   : quant_amax_scaler
//  Purpose  : Buffers one fp32 tensor while tracking max |x|, derives
//             scale = amax/128 and replays the tensor paired with that scale.
//  Revision : 1.0  initial release
// ============================================================================
module quant_amax_scaler
  import quant_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input wire logic           clk,
  input wire logic           rst_n,
  quant_amax_scaler_if.slave bus
);

  localparam int            AW       = $clog2(DEPTH);
  localparam int            CW       = AW + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] ADR_ONE  = AW'(1);

  amax_state_t   state_q,  state_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  fp32_t         amax_q,   amax_d;
  fp32_t         scale_q,  scale_d;
  logic          nonfin_q, nonfin_d;
  logic          trunc_q,  trunc_d;

  logic          buf_we;
  logic          buf_re;
  logic [AW-1:0] buf_raddr;
  fp32_t         buf_rdata;

  logic          in_fire;
  logic          out_fire;
  logic          last_out;

  assign bus.in_ready   = (state_q == COLLECT);
  assign bus.out_valid  = (state_q == REPLAY);
  assign last_out       = (state_q == REPLAY) && (rd_cnt_q == wr_cnt_q - CNT_ONE);
  assign bus.out_last   = last_out;
  assign bus.out_data   = buf_rdata;
  assign bus.out_scale  = scale_q;
  assign bus.err_nonfin = nonfin_q;
  assign bus.err_trunc  = trunc_q;

  assign in_fire  = bus.in_valid  && (state_q == COLLECT);
  assign out_fire = bus.out_ready && (state_q == REPLAY);

  // Next-state, counters, amax tracking, scale derivation and buffer control.
  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    amax_d    = amax_q;
    scale_d   = scale_q;
    nonfin_d  = nonfin_q;
    trunc_d   = trunc_q;
    buf_we    = 1'b0;
    buf_re    = 1'b0;
    // Read-ahead: while replaying, the next word is fetched on each handshake.
    buf_raddr = rd_cnt_q[AW-1:0] + ADR_ONE;

    case (state_q)
      COLLECT: begin
        if (in_fire) begin
          buf_we   = 1'b1;
          wr_cnt_d = wr_cnt_q + CNT_ONE;
          if (is_nonfinite(bus.in_data)) begin
            nonfin_d = 1'b1;
          end else if (magnitude(bus.in_data) > amax_q) begin
            amax_d = magnitude(bus.in_data);
          end
          // A full buffer closes the tensor even without in_last.
          if (bus.in_last || (wr_cnt_q == LAST_IDX)) begin
            state_d = SCALE;
            if (!bus.in_last) begin
              trunc_d = 1'b1;
            end
          end
        end
      end

      SCALE: begin
        scale_d   = amax_to_scale(amax_q);
        buf_re    = 1'b1;
        buf_raddr = '0;
        rd_cnt_d  = '0;
        state_d   = REPLAY;
      end

      REPLAY: begin
        if (out_fire) begin
          if (last_out) begin
            state_d  = COLLECT;
            wr_cnt_d = '0;
            rd_cnt_d = '0;
            amax_d   = '0;
            nonfin_d = 1'b0;
            trunc_d  = 1'b0;
          end else begin
            rd_cnt_d = rd_cnt_q + CNT_ONE;
            buf_re   = 1'b1;
          end
        end
      end

      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  // State, counters, amax, scale and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= COLLECT;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      amax_q   <= '0;
      scale_q  <= '0;
      nonfin_q <= 1'b0;
      trunc_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      amax_q   <= amax_d;
      scale_q  <= scale_d;
      nonfin_q <= nonfin_d;
      trunc_q  <= trunc_d;
    end
  end

  quant_replay_buf #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (buf_we),
    .waddr (wr_cnt_q[AW-1:0]),
    .wdata (bus.in_data),
    .re    (buf_re),
    .raddr (buf_raddr),
    .rdata (buf_rdata)
  );

endmodule
`default_nettype wire
